// File: rtl/sha3_multi_padder_pkg.sv
// Shared encodings and lookup helpers for the SHA-3/SHAKE sponge front-end.
// Rates are in bytes; suffix bytes are the FIPS-202 domain separators.
package sha3_multi_padder_pkg;

   localparam int MAX_RATE_BYTES = 168;
   localparam int OUT_W          = 8 * MAX_RATE_BYTES;

   typedef enum logic [1:0] {
      MODE_SHA3_256 = 2'b00,
      MODE_SHA3_512 = 2'b01,
      MODE_SHAKE128 = 2'b10,
      MODE_SHAKE256 = 2'b11
   } mode_e;

   typedef enum logic {
      ST_ABSORB = 1'b0,
      ST_FULL   = 1'b1
   } state_e;

   localparam logic [7:0] SFX_SHA3   = 8'h06;
   localparam logic [7:0] SFX_SHAKE  = 8'h1F;
   localparam logic [7:0] PAD_END    = 8'h80;
   localparam logic [7:0] RESET_RATE = 8'd136;

   function automatic logic [7:0] rate_of(input logic [1:0] mode);
      logic [7:0] r;
      r = 8'd136;
      case (mode_e'(mode))
         MODE_SHA3_256: r = 8'd136;
         MODE_SHA3_512: r = 8'd72;
         MODE_SHAKE128: r = 8'd168;
         MODE_SHAKE256: r = 8'd136;
         default:       r = 8'd136;
      endcase
      return r;
   endfunction

   // The top mode bit separates the SHAKE XOFs from the fixed-length SHA3 hashes.
   function automatic logic [7:0] suffix_of(input logic [1:0] mode);
      return mode[1] ? SFX_SHAKE : SFX_SHA3;
   endfunction

endpackage

// File: rtl/sha3_multi_padder_if.sv
// Message-in / block-out bundle between the message source, the padder and f_permutation.
// master = source/permutation side, slave = padder.
interface sha3_multi_padder_if #(
   parameter int IN_BYTES = 8,
   parameter int BN_W     = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1
);
   logic [8*IN_BYTES-1:0]                          in;
   logic                                           in_ready;
   logic                                           is_last;
   logic [BN_W-1:0]                                byte_num;
   logic [1:0]                                     mode;
   logic                                           buffer_full;
   logic [sha3_multi_padder_pkg::OUT_W-1:0]        out;
   logic                                           out_ready;
   logic                                           out_last;
   logic [7:0]                                     out_rate;
   logic                                           f_ack;

   modport master (
      output in, in_ready, is_last, byte_num, mode, f_ack,
      input  buffer_full, out, out_ready, out_last, out_rate
   );

   modport slave (
      input  in, in_ready, is_last, byte_num, mode, f_ack,
      output buffer_full, out, out_ready, out_last, out_rate
   );
endinterface

// File: rtl/sha3_multi_padder_pad_gen.sv
// Combinational lane steering: places an input word at the byte pointer and, on the
// final word, appends the domain suffix and the closing 0x80, zero-filling to the rate.
module sha3_multi_padder_pad_gen
   import sha3_multi_padder_pkg::*;
#(
   parameter int IN_BYTES = 8,
   parameter int BN_W     = 3
) (
   input  logic [8*IN_BYTES-1:0]     i_word,
   input  logic [BN_W-1:0]           i_byte_num,
   input  logic [7:0]                i_ptr,
   input  logic [7:0]                i_rate,
   input  logic [7:0]                i_suffix,
   input  logic                      i_is_last,
   output logic [MAX_RATE_BYTES-1:0] o_mask,
   output logic [OUT_W-1:0]          o_lanes
);

   localparam int LANES = 1 << BN_W;

   logic [7:0] w_in_b [LANES];

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      if (j < IN_BYTES) begin : g_v
         assign w_in_b[j] = i_word[8*(IN_BYTES-j)-1 -: 8];
      end else begin : g_z
         assign w_in_b[j] = 8'h00;
      end
   end

   int         w_p, w_r, w_bn, w_rel;
   logic [7:0] w_b;
   logic       w_en;

   always_comb begin
      o_mask  = '0;
      o_lanes = '0;
      w_p     = int'(i_ptr);
      w_r     = int'(i_rate);
      w_bn    = int'(i_byte_num);
      w_rel   = 0;
      w_b     = 8'h00;
      w_en    = 1'b0;
      for (int k = 0; k < MAX_RATE_BYTES; k++) begin
         w_rel = k - w_p;
         w_b   = (w_rel >= 0 && w_rel < IN_BYTES) ? w_in_b[w_rel[BN_W-1:0]] : 8'h00;
         if (i_is_last) begin
            // Final word owns every byte from the pointer to the end of the rate.
            w_en = (k >= w_p) && (k < w_r);
            if (w_rel >= w_bn)  w_b = 8'h00;
            if (k == w_p + w_bn) w_b = w_b ^ i_suffix;
            if (k == w_r - 1)    w_b = w_b ^ PAD_END;
         end else begin
            w_en = (w_rel >= 0) && (w_rel < IN_BYTES);
         end
         o_mask[k]                 = w_en;
         o_lanes[OUT_W-1-8*k -: 8] = w_en ? w_b : 8'h00;
      end
   end

endmodule

// File: rtl/sha3_multi_padder.sv
// Sponge absorb buffer + FIPS-202 padder; a block-completing word raises out_ready next cycle.
// While a block waits for f_ack, buffer_full holds the source off (including the f_ack cycle).
module sha3_multi_padder
   import sha3_multi_padder_pkg::*;
#(
   parameter int IN_BYTES = 8,
   parameter int BN_W     = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   sha3_multi_padder_if.slave    bus
);

   if (!(IN_BYTES == 1 || IN_BYTES == 2 || IN_BYTES == 4 || IN_BYTES == 8)) begin : g_bad_param
      $fatal(1, "sha3_multi_padder: IN_BYTES must be 1, 2, 4 or 8");
   end

   state_e                    r_state, w_next_state;
   logic [OUT_W-1:0]          r_buf;
   logic [7:0]                r_ptr, r_rate, r_sfx;
   logic                      r_last, r_in_msg;

   logic                      w_full, w_accept, w_blk_done;
   logic [7:0]                w_rate, w_sfx, w_ptr_nxt;
   logic [MAX_RATE_BYTES-1:0] w_mask;
   logic [OUT_W-1:0]          w_lanes, w_bmask;

   assign w_full    = (r_state == ST_FULL);
   assign w_accept  = bus.in_ready & ~w_full;
   // Mode is latched by the first accepted word; later words reuse the latched values.
   assign w_rate    = r_in_msg ? r_rate : rate_of(bus.mode);
   assign w_sfx     = r_in_msg ? r_sfx  : suffix_of(bus.mode);
   assign w_ptr_nxt = r_ptr + 8'(IN_BYTES);
   assign w_blk_done = w_accept & (bus.is_last | (w_ptr_nxt == w_rate));

   sha3_multi_padder_pad_gen #(
      .IN_BYTES (IN_BYTES),
      .BN_W     (BN_W)
   ) u_pad_gen (
      .i_word     (bus.in),
      .i_byte_num (bus.byte_num),
      .i_ptr      (r_ptr),
      .i_rate     (w_rate),
      .i_suffix   (w_sfx),
      .i_is_last  (bus.is_last),
      .o_mask     (w_mask),
      .o_lanes    (w_lanes)
   );

   for (genvar k = 0; k < MAX_RATE_BYTES; k++) begin : g_bmask
      assign w_bmask[OUT_W-1-8*k -: 8] = {8{w_mask[k]}};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_ABSORB;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_ABSORB: if (w_blk_done)  w_next_state = ST_FULL;
         ST_FULL:   if (bus.f_ack)   w_next_state = ST_ABSORB;
         default:                    w_next_state = ST_ABSORB;
      endcase
   end

   always_comb begin
      bus.out_ready   = w_full;
      bus.buffer_full = w_full;
      bus.out         = r_buf;
      bus.out_last    = r_last;
      bus.out_rate    = r_rate;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_buf    <= '0;
         r_ptr    <= '0;
         r_rate   <= RESET_RATE;
         r_sfx    <= SFX_SHA3;
         r_last   <= 1'b0;
         r_in_msg <= 1'b0;
      end else if (w_full && bus.f_ack) begin
         r_buf  <= '0;
         r_ptr  <= '0;
         r_last <= 1'b0;
         if (r_last) r_in_msg <= 1'b0;
      end else if (w_accept) begin
         r_buf  <= (r_buf & ~w_bmask) | w_lanes;
         r_ptr  <= bus.is_last ? r_ptr : w_ptr_nxt;
         r_last <= bus.is_last;
         if (!r_in_msg) begin
            r_in_msg <= 1'b1;
            r_rate   <= w_rate;
            r_sfx    <= w_sfx;
         end
      end
   end

endmodule
